hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage MIPS datapath. It sits beside the ID/EX pipeline register and decides each cycle whether PC, IF/ID and ID/EX advance, hold, flush or take a bubble. It covers three cases: load-use hazards, branch-in-ID operand hazards and taken-branch flushes. It also sequences multi-cycle multiply operations in EX with an internal FSM, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs and pipeline-register enables.
// Combinational path; the controller applies backpressure to the front end through the enables only.
interface hazard_ctrl_if;
   logic [4:0]  IDRs;
   logic [4:0]  IDRt;
   logic        IDUsesRs;
   logic        IDUsesRt;
   logic        IDIsBranch;
   logic        BranchTaken;
   logic        IDEXMemRead;
   logic        IDEXRegWrite;
   logic [4:0]  IDEXDestReg;
   logic        EXMEMMemRead;
   logic [4:0]  EXMEMDestReg;
   logic        EXIsMul;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic        IDEXWrite;
   logic        IDEXBubble;
   logic        EXMEMBubble;
   logic        Busy;
   logic [15:0] StallCycles;

   modport master (
      output IDRs, IDRt, IDUsesRs, IDUsesRt, IDIsBranch, BranchTaken,
             IDEXMemRead, IDEXRegWrite, IDEXDestReg, EXMEMMemRead, EXMEMDestReg, EXIsMul,
      input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, Busy, StallCycles
   );

   modport slave (
      input  IDRs, IDRt, IDUsesRs, IDUsesRt, IDIsBranch, BranchTaken,
             IDEXMemRead, IDEXRegWrite, IDEXDestReg, EXMEMMemRead, EXMEMDestReg, EXIsMul,
      output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, Busy, StallCycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller with multi-cycle multiply sequencer.
// Enables are zero-latency combinational; stalls/holds backpressure PC and IF/ID by deasserting their writes.
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic clk,
   input  logic Reset,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_LAST = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic hold;
   logic rs_vs_ex, rt_vs_ex, rs_vs_mem, rt_vs_mem;
   logic load_use, branch_stall, stall;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (bus.EXIsMul) begin
               cnt_d   = CNT_INIT;
               state_d = (MUL_CYCLES == 2) ? MUL_LAST : MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            if (cnt_q == 4'd1) state_d = MUL_LAST;
            else               cnt_d   = cnt_q - 4'd1;
         end
         MUL_LAST: state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // Register $0 is hard-wired, so a zero destination never creates a dependency.
   always_comb begin
      hold      = ((state_q == RUN) && bus.EXIsMul) || (state_q == MUL_BUSY);
      rs_vs_ex  = bus.IDUsesRs && (bus.IDRs == bus.IDEXDestReg) && (bus.IDEXDestReg != 5'd0);
      rt_vs_ex  = bus.IDUsesRt && (bus.IDRt == bus.IDEXDestReg) && (bus.IDEXDestReg != 5'd0);
      rs_vs_mem = bus.IDUsesRs && (bus.IDRs == bus.EXMEMDestReg) && (bus.EXMEMDestReg != 5'd0);
      rt_vs_mem = bus.IDUsesRt && (bus.IDRt == bus.EXMEMDestReg) && (bus.EXMEMDestReg != 5'd0);
      load_use     = bus.IDEXMemRead && (rs_vs_ex || rt_vs_ex);
      branch_stall = bus.IDIsBranch &&
                     ((bus.IDEXRegWrite && (rs_vs_ex || rt_vs_ex)) ||
                      (bus.EXMEMMemRead && (rs_vs_mem || rt_vs_mem)));
      stall = load_use || branch_stall;

      bus.PCWrite     = 1'b1;
      bus.IFIDWrite   = 1'b1;
      bus.IFIDFlush   = 1'b0;
      bus.IDEXWrite   = 1'b1;
      bus.IDEXBubble  = 1'b0;
      bus.EXMEMBubble = 1'b0;
      if (Reset) begin
         bus.PCWrite     = 1'b0;
         bus.IFIDWrite   = 1'b0;
         bus.IDEXWrite   = 1'b0;
         bus.IDEXBubble  = 1'b1;
         bus.EXMEMBubble = 1'b1;
      end else if (hold) begin
         bus.PCWrite     = 1'b0;
         bus.IFIDWrite   = 1'b0;
         bus.IDEXWrite   = 1'b0;
         bus.EXMEMBubble = 1'b1;
      end else if (stall) begin
         // A stalled branch is re-resolved next cycle, so BranchTaken is not acted on here.
         bus.PCWrite    = 1'b0;
         bus.IFIDWrite  = 1'b0;
         bus.IDEXBubble = 1'b1;
      end else if (bus.BranchTaken) begin
         bus.IFIDFlush = 1'b1;
      end
      bus.Busy        = (state_q != RUN);
      bus.StallCycles = stall_cnt_q;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!bus.PCWrite && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

   logic clk;
   logic Reset;

   hazard_ctrl_if m4 ();
   hazard_ctrl_if m2 ();

   hazard_ctrl #(.MUL_CYCLES(4)) dut4 (.clk(clk), .Reset(Reset), .bus(m4));
   hazard_ctrl #(.MUL_CYCLES(2)) dut2 (.clk(clk), .Reset(Reset), .bus(m2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output order: {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, Busy}
   localparam logic [6:0] O_DEF   = 7'b1101000;
   localparam logic [6:0] O_DEFB  = 7'b1101001;
   localparam logic [6:0] O_STALL = 7'b0001100;
   localparam logic [6:0] O_FLUSH = 7'b1111000;
   localparam logic [6:0] O_HOLD0 = 7'b0000010;
   localparam logic [6:0] O_HOLD1 = 7'b0000011;
   localparam logic [6:0] O_RST   = 7'b0000110;

   typedef struct {
      string       name;
      int          sel;
      logic [22:0] vec;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model_cnt[2];

   wire [22:0] act4 = {m4.PCWrite, m4.IFIDWrite, m4.IFIDFlush, m4.IDEXWrite,
                       m4.IDEXBubble, m4.EXMEMBubble, m4.Busy, m4.StallCycles};
   wire [22:0] act2 = {m2.PCWrite, m2.IFIDWrite, m2.IFIDFlush, m2.IDEXWrite,
                       m2.IDEXBubble, m2.EXMEMBubble, m2.Busy, m2.StallCycles};

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [22:0] act;
         e = sb.pop_front();
         act = (e.sel == 0) ? act4 : act2;
         checks++;
         if (act !== e.vec) begin
            failures++;
            $display("FAIL %s: got outs=%b stall=%h, want outs=%b stall=%h",
                     e.name, act[22:16], act[15:0], e.vec[22:16], e.vec[15:0]);
         end
      end
   end

   task automatic clr_inputs();
      m4.IDRs = '0; m4.IDRt = '0; m4.IDUsesRs = 0; m4.IDUsesRt = 0; m4.IDIsBranch = 0;
      m4.BranchTaken = 0; m4.IDEXMemRead = 0; m4.IDEXRegWrite = 0; m4.IDEXDestReg = '0;
      m4.EXMEMMemRead = 0; m4.EXMEMDestReg = '0; m4.EXIsMul = 0;
      m2.IDRs = '0; m2.IDRt = '0; m2.IDUsesRs = 0; m2.IDUsesRt = 0; m2.IDIsBranch = 0;
      m2.BranchTaken = 0; m2.IDEXMemRead = 0; m2.IDEXRegWrite = 0; m2.IDEXDestReg = '0;
      m2.EXMEMMemRead = 0; m2.EXMEMDestReg = '0; m2.EXIsMul = 0;
   endtask

   task automatic load_use4(input logic [4:0] dest, input logic [4:0] rs);
      m4.IDEXMemRead = 1; m4.IDEXDestReg = dest; m4.IDRs = rs; m4.IDUsesRs = 1;
   endtask

   // Queue the expectation for this cycle, then advance to just after the next rising edge.
   task automatic step(input string name, input int sel, input logic [6:0] o);
      exp_t e;
      if (Reset) begin
         model_cnt[0] = '0;
         model_cnt[1] = '0;
      end
      e.name = name;
      e.sel  = sel;
      e.vec  = {o, model_cnt[sel]};
      sb.push_back(e);
      if (!Reset && !o[6] && model_cnt[sel] != 16'hFFFF) model_cnt[sel] = model_cnt[sel] + 16'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_silent(input int n);
      for (int i = 0; i < n; i++) begin
         if (model_cnt[0] != 16'hFFFF) model_cnt[0] = model_cnt[0] + 16'd1;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      model_cnt[0] = '0;
      model_cnt[1] = '0;
      Reset = 1'b1;
      clr_inputs();
      @(posedge clk);
      #1;
      step("reset_outputs", 0, O_RST);
      Reset = 1'b0;
      step("idle_default", 0, O_DEF);

      load_use4(5'd8, 5'd8);
      step("load_use_rs", 0, O_STALL);
      clr_inputs();
      step("stall_count_1", 0, O_DEF);
      load_use4(5'd0, 5'd0);
      step("load_use_r0", 0, O_DEF);
      clr_inputs();
      m4.IDEXMemRead = 1; m4.IDEXDestReg = 5'd8; m4.IDRt = 5'd8; m4.IDUsesRt = 0;
      step("load_use_rt_unused", 0, O_DEF);
      m4.IDUsesRt = 1;
      step("load_use_rt", 0, O_STALL);

      clr_inputs();
      m4.IDIsBranch = 1; m4.IDRt = 5'd5; m4.IDUsesRt = 1; m4.IDEXRegWrite = 1;
      m4.IDEXDestReg = 5'd5; m4.BranchTaken = 1;
      step("branch_ex_stall", 0, O_STALL);
      m4.IDEXDestReg = 5'd6;
      step("branch_flush", 0, O_FLUSH);
      clr_inputs();
      m4.IDIsBranch = 1; m4.IDRs = 5'd9; m4.IDUsesRs = 1; m4.EXMEMMemRead = 1; m4.EXMEMDestReg = 5'd9;
      step("branch_mem_stall", 0, O_STALL);
      m4.EXMEMMemRead = 0;
      step("branch_mem_noload", 0, O_DEF);
      m4.IDIsBranch = 0; m4.IDEXRegWrite = 1; m4.IDEXDestReg = 5'd9;
      step("alu_dep_no_stall", 0, O_DEF);

      clr_inputs();
      m4.EXIsMul = 1; m4.BranchTaken = 1;
      load_use4(5'd8, 5'd8);
      step("mul_hold_run", 0, O_HOLD0);
      step("mul_hold_busy1", 0, O_HOLD1);
      step("mul_hold_busy2", 0, O_HOLD1);
      m4.IDEXMemRead = 0; m4.BranchTaken = 0;
      step("mul_last_release", 0, O_DEFB);
      step("mul_retrigger", 0, O_HOLD0);
      step("mul_retrig_busy", 0, O_HOLD1);
      Reset = 1'b1;
      step("reset_mid_mul", 0, O_RST);
      Reset = 1'b0;
      m4.EXIsMul = 0;
      step("after_reset_default", 0, O_DEF);

      clr_inputs();
      m2.EXIsMul = 1;
      step("mul2_hold", 1, O_HOLD0);
      step("mul2_last", 1, O_DEFB);
      step("mul2_retrigger", 1, O_HOLD0);
      m2.EXIsMul = 0;
      step("mul2_last_again", 1, O_DEFB);
      step("mul2_run", 1, O_DEF);

      clr_inputs();
      load_use4(5'd3, 5'd3);
      step("sat_first", 0, O_STALL);
      run_silent(70000);
      step("sat_ffff", 0, O_STALL);
      step("sat_stays", 0, O_STALL);
      clr_inputs();
      step("sat_idle", 0, O_DEF);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
